logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the logic unit (2..8).
REQ-002 Parameter WIDTH, default 8: operand/result width; all ops are bitwise.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  N_REQ  per-requester request; held high until granted.
REQ-006 op  input  3*N_REQ  per-requester op code, slice i = op[3i+2:3i].
REQ-007 a  input  WIDTH*N_REQ  per-requester operand A, slice i.
REQ-008 b  input  WIDTH*N_REQ  per-requester operand B, slice i; ignored for NOT.
REQ-009 gnt  output  N_REQ  one-hot grant, combinational, same cycle as acceptance.
REQ-010 res_valid  output  1  result register holds a valid result.
REQ-011 res_ready  input  1  consumer accepts result when res_valid and res_ready are high at an edge.
REQ-012 res_id  output  clog2(N_REQ)  index of requester owning the result.
REQ-013 res_data  output  WIDTH  operation result.
REQ-014 res_err  output  1  result came from a reserved op code.

Function
REQ-015 Op encoding: 0 OR, 1 NOR, 2 AND, 3 NAND, 4 XOR, 5 XNOR, 6 NOT(a), 7 reserved; reserved gives res_data=0 and res_err=1.
REQ-016 Accept condition: accept = (|req) && (!res_valid || res_ready).
REQ-017 When accept is high, gnt is asserted for exactly one requester.
REQ-018 The granted requester is the first asserted req at or after ptr, searching upward modulo N_REQ.
REQ-019 When accept is low, gnt is all-zero.
REQ-020 On an accepting edge, the winner's op/a/b are computed and registered.
REQ-021 On an accepting edge, res_valid=1, res_id=winner, and ptr=(winner+1) mod N_REQ.
REQ-022 Latency: result is visible one cycle after the gnt cycle.
REQ-023 Throughput is one result per cycle while res_ready is high.
REQ-024 If res_valid && !res_ready, the result registers hold stable, gnt stays 0 and ptr is unchanged (backpressure).
REQ-025 If res_valid && res_ready with no req, res_valid clears next cycle.
REQ-026 If res_valid && res_ready and a req is present, the drain and new accept happen on the same edge, with no bubble.
REQ-027 ptr wraps from N_REQ-1 to 0.
REQ-028 Fairness: with all req held high, grants rotate 0,1,...,N_REQ-1,0; no requester waits more than N_REQ-1 grants.
REQ-029 A req deasserted before grant is dropped silently; no state records it.
REQ-030 FSM states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-031 EMPTY->FULL on accept.
REQ-032 FULL->FULL on drain with accept, or on stall.
REQ-033 FULL->EMPTY on drain without accept.

Reset
REQ-034 While rst is high at an edge, the block sets ptr=0, res_valid=0, res_id=0, res_data=0, res_err=0 and state=EMPTY.
REQ-035 While rst is high, gnt is all-zero regardless of req.
REQ-036 Reset mid-operation discards any held result; no grant is issued in the reset cycle.
REQ-037 The first accept after reset deasserts favors requester 0.

Structure
REQ-038 A shared package holds the op code constants/enum (OP_OR..OP_NOT, OP_RSVD) and the N_REQ/WIDTH defaults.
REQ-039 The round-robin priority select is a sub-module rr_arbiter (inputs req, ptr, en; output one-hot gnt and binary winner).
REQ-040 The bitwise op mux stays inline in logic_unit_arbiter.

Verification
REQ-041 Single request: req=0001, op0=4, a0=8'hF0, b0=8'h3C -> gnt=0001 that cycle; next cycle res_valid=1, res_id=0, res_data=8'hCC, res_err=0.
REQ-042 Rotation: req=1111 held, res_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles; res_valid continuously 1.
REQ-043 Backpressure: res_valid=1, res_ready=0 for 3 cycles with req=0110 -> gnt=0 and res_data/res_id stable; on res_ready=1, gnt=0010 the same cycle.
REQ-044 Ops and reserved: requester 2 op=6, a=8'hA5 -> res_data=8'h5A; op=7 -> res_data=0, res_err=1.
REQ-045 Reset mid-stream: rst=1 while res_valid=1 and req=1000 -> next cycle res_valid=0 and gnt=0; after release the first grant goes to requester 3 (ptr=0 search) and the following grant to 0 if requested.
REQ-046 Wrap: ptr=3, req=1001 -> grant 3, then ptr=0 -> grant 0.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter_pkg
// Shared definitions for the logic-unit arbiter slice: default sizing, the
// bitwise op-code encoding and the result-register FSM state encoding.
// ---------------------------------------------------------------------------
package logic_unit_arbiter_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 8;

  // 3-bit op code carried per requester on the op bus.
  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_NOR  = 3'd1,
    OP_AND  = 3'd2,
    OP_NAND = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  // The result register is either empty or holding one unconsumed result.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage : logic_unit_arbiter_pkg

// File: rtl/logic_unit_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin select: picks the first asserted request at or
// after ptr, searching upward and wrapping modulo N_REQ.
// Ports:
//   req    - request vector
//   ptr    - index with highest priority this cycle
//   en     - grant enable; gnt is all-zero when low
//   gnt    - one-hot grant
//   winner - binary index of the selected requester (valid when |req)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  input  logic                     en,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int unsigned IDW = $clog2(N_REQ);

  logic           found_hi_s;
  logic           found_lo_s;
  logic           take_hi_s;
  logic           take_lo_s;
  logic [IDW-1:0] w_hi_s;
  logic [IDW-1:0] w_lo_s;

  // Two priority scans: lowest request at/above ptr wins; failing that the
  // lowest request overall, which is the wrapped part of the search.
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    take_hi_s  = 1'b0;
    take_lo_s  = 1'b0;
    w_hi_s     = '0;
    w_lo_s     = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      take_hi_s  = req[i] && (i >= int'(ptr)) && !found_hi_s;
      take_lo_s  = req[i] && !found_lo_s;
      w_hi_s     = take_hi_s ? i[IDW-1:0] : w_hi_s;
      w_lo_s     = take_lo_s ? i[IDW-1:0] : w_lo_s;
      found_hi_s = found_hi_s | take_hi_s;
      found_lo_s = found_lo_s | take_lo_s;
    end
    winner = found_hi_s ? w_hi_s : w_lo_s;
  end

  // Expand the winner into a one-hot grant, gated by enable and any request.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      gnt[i] = en && found_lo_s && (winner == i[IDW-1:0]);
    end
  end

endmodule : rr_arbiter

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
// N_REQ requesters share one bitwise logic unit. A round-robin arbiter picks
// one request per cycle whenever the single result register is empty or is
// being drained in the same cycle; the winner's operation is computed and
// registered together with its index.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req[N_REQ]          - per-requester request
//   op[3*N_REQ]         - per-requester op code, slice i = op[3i+2:3i]
//   a, b[WIDTH*N_REQ]   - per-requester operands (b unused for NOT)
//   gnt[N_REQ]          - one-hot grant, combinational, in the accept cycle
//   res_valid/res_ready - result handshake
//   res_id/data/err     - owner index, result, reserved-op flag
// ---------------------------------------------------------------------------
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [3*N_REQ-1:0]       op,
  input  logic [WIDTH*N_REQ-1:0]   a,
  input  logic [WIDTH*N_REQ-1:0]   b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_err
);

  localparam int unsigned IDW = $clog2(N_REQ);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic           err_q, err_d;

  logic           accept_s;
  logic [IDW-1:0] winner_s;
  op_e            op_sel_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;
  logic [WIDTH-1:0] alu_s;
  logic           alu_err_s;

  assign res_valid = (state_q == ST_FULL);
  assign res_id    = id_q;
  assign res_data  = data_q;
  assign res_err   = err_q;

  // Reset is folded in so no grant is ever issued in a reset cycle.
  assign accept_s = !rst && (|req) && (!res_valid || res_ready);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .en     (accept_s),
    .gnt    (gnt),
    .winner (winner_s)
  );

  assign op_sel_s = op_e'(op[3*int'(winner_s) +: 3]);
  assign a_sel_s  = a[WIDTH*int'(winner_s) +: WIDTH];
  assign b_sel_s  = b[WIDTH*int'(winner_s) +: WIDTH];

  // Bitwise op mux for the winning requester.
  always_comb begin
    alu_s     = '0;
    alu_err_s = 1'b0;
    case (op_sel_s)
      OP_OR:   alu_s = a_sel_s | b_sel_s;
      OP_NOR:  alu_s = ~(a_sel_s | b_sel_s);
      OP_AND:  alu_s = a_sel_s & b_sel_s;
      OP_NAND: alu_s = ~(a_sel_s & b_sel_s);
      OP_XOR:  alu_s = a_sel_s ^ b_sel_s;
      OP_XNOR: alu_s = ~(a_sel_s ^ b_sel_s);
      OP_NOT:  alu_s = ~a_sel_s;
      OP_RSVD: begin
        alu_s     = '0;
        alu_err_s = 1'b1;
      end
      default: begin
        alu_s     = '0;
        alu_err_s = 1'b1;
      end
    endcase
  end

  // Next-state and result-register load logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    if (accept_s) begin
      id_d   = winner_s;
      data_d = alu_s;
      err_d  = alu_err_s;
      ptr_d  = (winner_s == IDW'(N_REQ - 1)) ? '0 : winner_s + IDW'(1'b1);
    end else begin
      ptr_d = ptr_q;
    end
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // A drain with a fresh accept refills on the same edge (no bubble).
        if (accept_s) begin
          state_d = ST_FULL;
        end else if (res_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule : logic_unit_arbiter

// File: tb/tb_logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_arbiter
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the round-robin logic unit held in the bench.
// ---------------------------------------------------------------------------
module tb_logic_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [3*N-1:0] op;
  logic [W*N-1:0] a;
  logic [W*N-1:0] b;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic           res_ready;
  logic [1:0]     res_id;
  logic [W-1:0]   res_data;
  logic           res_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic           m_valid;
  int             m_id;
  logic [W-1:0]   m_data;
  logic           m_err;
  int             m_ptr;
  logic [N-1:0]   last_gnt;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'd0: return x | y;
      3'd1: return ~(x | y);
      3'd2: return x & y;
      3'd3: return ~(x & y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return '0;
    endcase
  endfunction

  task automatic set_op(input int i, input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    op[3*i +: 3] = o;
    a[W*i +: W]  = av;
    b[W*i +: W]  = bv;
  endtask

  // One clock: check the combinational grant, advance the model, check registers.
  task automatic step();
    logic [N-1:0] eg;
    int           w;
    logic         acc;
    logic         was_rst;
    #2;
    eg = '0;
    w = 0;
    acc = 1'b0;
    was_rst = rst;
    if (!rst && (req != '0) && (!m_valid || res_ready)) begin
      acc = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (eg == '0 && req[(m_ptr + k) % N]) begin
          w = (m_ptr + k) % N;
          eg[w] = 1'b1;
        end
      end
    end
    check_eq("gnt", 32'(gnt), 32'(eg));
    last_gnt = gnt;
    if (rst) begin
      m_valid = 1'b0; m_id = 0; m_data = '0; m_err = 1'b0; m_ptr = 0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_id    = w;
      m_data  = ref_op(op[3*w +: 3], a[W*w +: W], b[W*w +: W]);
      m_err   = (op[3*w +: 3] == 3'd7);
      m_ptr   = (w + 1) % N;
    end else if (m_valid && res_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("res_valid", 32'(res_valid), 32'(m_valid));
    if (m_valid || was_rst) begin
      check_eq("res_id", 32'(res_id), 32'(m_id));
      check_eq("res_data", 32'(res_data), 32'(m_data));
      check_eq("res_err", 32'(res_err), 32'(m_err));
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; a = '0; b = '0; res_ready = 1'b1;
    m_valid = 1'b0; m_id = 0; m_data = '0; m_err = 1'b0; m_ptr = 0;
    step();
    step();
    rst = 1'b0;

    // Single XOR request
    set_op(0, 3'd4, 8'hF0, 8'h3C);
    req = 4'b0001;
    step();
    check_eq("single_gnt", 32'(last_gnt), 32'h1);
    check_eq("single_data", 32'(res_data), 32'hCC);
    check_eq("single_id", 32'(res_id), 32'h0);

    // Rotation with all requesters active, from a fresh reset
    rst = 1'b1; req = '0; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 3'(i), 8'($urandom), 8'($urandom));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("rot_id", 32'(res_id), 32'(i % N));
      check_eq("rot_valid", 32'(res_valid), 32'h1);
    end

    // Backpressure: three stalled cycles then release
    res_ready = 1'b0; req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_gnt", 32'(last_gnt), 32'h0);
      check_eq("bp_id", 32'(res_id), 32'h0);
    end
    res_ready = 1'b1;
    step();
    check_eq("bp_release_gnt", 32'(last_gnt), 32'h2);

    // NOT and reserved op on requester 2
    req = 4'b0100;
    set_op(2, 3'd6, 8'hA5, 8'h00);
    step();
    check_eq("not_data", 32'(res_data), 32'h5A);
    set_op(2, 3'd7, 8'hA5, 8'h33);
    step();
    check_eq("rsvd_data", 32'(res_data), 32'h0);
    check_eq("rsvd_err", 32'(res_err), 32'h1);

    // Wrap: ptr sits at 3 now
    req = 4'b1001;
    step();
    check_eq("wrap_gnt3", 32'(last_gnt), 32'h8);
    step();
    check_eq("wrap_gnt0", 32'(last_gnt), 32'h1);

    // Reset while holding a result
    req = 4'b1000; rst = 1'b1;
    step();
    check_eq("rst_gnt", 32'(last_gnt), 32'h0);
    check_eq("rst_valid", 32'(res_valid), 32'h0);
    rst = 1'b0;
    step();
    check_eq("post_rst_gnt3", 32'(last_gnt), 32'h8);
    req = 4'b1001;
    step();
    check_eq("post_rst_gnt0", 32'(last_gnt), 32'h1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req       = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      op        = 12'($urandom);
      a         = $urandom;
      b         = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_logic_unit_arbiter
